// File: rtl/seg_mux_driver.sv
// -----------------------------------------------------------------------------
// seg_mux_driver
// Time-multiplexed driver for a 4-digit, 8-segment (active-low) display.
// A frame snapshot of the four segment patterns is taken at the start of each
// frame. Each digit then gets a slot of REFRESH_DIV clocks. The first
// BLANK_CYCLES clocks of a slot are dark (anti-ghosting) and the rest drive the
// digit. Optional whole-display blinking toggles visibility every BLINK_FRAMES
// frames.
//
// Ports
//   Clk100M             : clock, all logic on the rising edge
//   Reset               : synchronous, active-high reset
//   segIn0..segIn3 [7:0]: active-low segment patterns {dp,g..a} for digits 0..3
//   blink               : 1 enables whole-display blinking
//   an [3:0]            : active-low digit anodes (an[k] low selects digit k)
//   seg [7:0]           : active-low cathodes {dp,g..a}
//   frame_tick          : one-cycle pulse after the last clock of each frame
// -----------------------------------------------------------------------------
module seg_mux_driver #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic       Clk100M,
  input  logic       Reset,
  input  logic [7:0] segIn0,
  input  logic [7:0] segIn1,
  input  logic [7:0] segIn2,
  input  logic [7:0] segIn3,
  input  logic       blink,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK  = CW'(BLANK_CYCLES);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cntNext;
  logic [1:0]      dig;
  logic [1:0]      digNext;
  logic            slotWrap;
  logic            frameEnd;
  logic [3:0]      anNext;
  logic [7:0]      segNext;
  logic [7:0]      snap [4];
  logic [BW-1:0]   blinkCnt;
  logic            hidden;

  // Slot counter / digit advance, FSM next state and next output values.
  always_comb begin
    cntNext   = cnt + CNT_ONE;
    digNext   = dig;
    stateNext = state;
    slotWrap  = (cnt == CNT_LAST);
    frameEnd  = slotWrap && (dig == 2'd3);
    anNext    = 4'b1111;
    segNext   = 8'hFF;

    if (slotWrap) begin
      cntNext = CNT_ZERO;
      digNext = dig + 2'd1;
    end else begin
      cntNext = cnt + CNT_ONE;
    end

    // State tracks the counter value it will hold after this edge, so the
    // state register always agrees with cnt (BLANK iff cnt < BLANK_CYCLES).
    case (state)
      BLANK: begin
        if (cntNext == CNT_BLANK) begin
          stateNext = DRIVE;
        end else begin
          stateNext = BLANK;
        end
      end
      DRIVE: begin
        if (slotWrap) begin
          stateNext = BLANK;
        end else begin
          stateNext = DRIVE;
        end
      end
      default: stateNext = BLANK;
    endcase

    if ((state == DRIVE) && !hidden) begin
      anNext  = ~(4'b0001 << dig);
      segNext = snap[dig];
    end else begin
      anNext  = 4'b1111;
      segNext = 8'hFF;
    end
  end

  // Scan state, registered outputs and the per-frame snapshot.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      cnt        <= CNT_ZERO;
      dig        <= 2'd0;
      state      <= BLANK;
      an         <= 4'b1111;
      seg        <= 8'hFF;
      frame_tick <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        snap[k] <= 8'hFF;
      end
    end else begin
      cnt        <= cntNext;
      dig        <= digNext;
      state      <= stateNext;
      an         <= anNext;
      seg        <= segNext;
      frame_tick <= frameEnd;
      // Snapshot only at frame start so a frame never mixes old and new codes.
      if ((cnt == CNT_ZERO) && (dig == 2'd0)) begin
        snap[0] <= segIn0;
        snap[1] <= segIn1;
        snap[2] <= segIn2;
        snap[3] <= segIn3;
      end else begin
        snap <= snap;
      end
    end
  end

  // Blink phase: counts frame ends while blinking, toggles every BLINK_FRAMES.
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      blinkCnt <= '0;
      hidden   <= 1'b0;
    end else if (!blink) begin
      blinkCnt <= '0;
      hidden   <= 1'b0;
    end else if (frame_tick) begin
      if (blinkCnt == BLINK_LAST) begin
        blinkCnt <= '0;
        hidden   <= ~hidden;
      end else begin
        blinkCnt <= blinkCnt + BLINK_ONE;
      end
    end else begin
      blinkCnt <= blinkCnt;
      hidden   <= hidden;
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_mux_driver
// Directed self-checking bench for seg_mux_driver (REFRESH_DIV=8,
// BLANK_CYCLES=2, BLINK_FRAMES=2) plus a default-parameter instance used to
// check the default blank time.
// -----------------------------------------------------------------------------
module tb_seg_mux_driver;

  logic       clk;
  logic       rst;
  logic       rstDef;
  logic [7:0] segIn0, segIn1, segIn2, segIn3;
  logic       blink;
  logic       blinkDef;
  logic [3:0] an, defAn;
  logic [7:0] seg, defSeg;
  logic       frame_tick, defFt;

  int nAsserts = 0;
  int nFail    = 0;
  logic prevFt    = 1'b0;
  logic prevDefFt = 1'b0;

  seg_mux_driver #(.REFRESH_DIV(8), .BLANK_CYCLES(2), .BLINK_FRAMES(2)) dut (
    .Clk100M(clk), .Reset(rst),
    .segIn0(segIn0), .segIn1(segIn1), .segIn2(segIn2), .segIn3(segIn3),
    .blink(blink), .an(an), .seg(seg), .frame_tick(frame_tick)
  );

  seg_mux_driver dutDef (
    .Clk100M(clk), .Reset(rstDef),
    .segIn0(segIn0), .segIn1(segIn1), .segIn2(segIn2), .segIn3(segIn3),
    .blink(blinkDef), .an(defAn), .seg(defSeg), .frame_tick(defFt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge and check the invariants.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    chk("ft_double", 32'(prevFt && frame_tick), 32'd0);
    chk("def_an_onehot", 32'($countones(~defAn) <= 1), 32'd1);
    chk("def_ft_double", 32'(prevDefFt && defFt), 32'd0);
    prevFt    = frame_tick;
    prevDefFt = defFt;
  endtask

  // Check one 8-clock digit slot. act: 1 = change segIn1/segIn3 mid-slot,
  // 2 = raise blink after the first clock, 3 = drop blink after the first clock.
  task automatic checkSlot(input int d, input logic [7:0] s, input bit vis, input int act);
    logic [3:0] one;
    logic [3:0] expAn;
    logic [7:0] expSeg;
    logic       expFt;
    one = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i >= 2 && vis) begin
        expAn  = ~(one << d);
        expSeg = s;
      end else begin
        expAn  = 4'b1111;
        expSeg = 8'hFF;
      end
      expFt = (d == 3) && (i == 7);
      chk($sformatf("an d%0d c%0d", d, i), 32'(an), 32'(expAn));
      chk($sformatf("seg d%0d c%0d", d, i), 32'(seg), 32'(expSeg));
      chk($sformatf("ft d%0d c%0d", d, i), 32'(frame_tick), 32'(expFt));
      if (act == 1 && i == 4) begin
        segIn1 = 8'h92;
        segIn3 = 8'h99;
      end
      if (act == 2 && i == 0) blink = 1'b1;
      if (act == 3 && i == 0) blink = 1'b0;
    end
  endtask

  task automatic checkFrame(input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2, input logic [7:0] s3, input bit vis);
    checkSlot(0, s0, vis, 0);
    checkSlot(1, s1, vis, 0);
    checkSlot(2, s2, vis, 0);
    checkSlot(3, s3, vis, 0);
  endtask

  initial begin
    rst = 1'b1; rstDef = 1'b1; blink = 1'b0; blinkDef = 1'b0;
    segIn0 = 8'hC0; segIn1 = 8'hF9; segIn2 = 8'hA4; segIn3 = 8'hB0;

    // Reset state
    tick(); tick();
    chk("rst_an", 32'(an), 32'h0000000F);
    chk("rst_seg", 32'(seg), 32'h000000FF);
    chk("rst_ft", 32'(frame_tick), 32'd0);
    rst = 1'b0;

    // Scan order, two frames
    checkFrame(8'hC0, 8'hF9, 8'hA4, 8'hB0, 1'b1);
    // Tear-free: inputs 1 and 3 change during digit 2's slot
    checkSlot(0, 8'hC0, 1'b1, 0);
    checkSlot(1, 8'hF9, 1'b1, 0);
    checkSlot(2, 8'hA4, 1'b1, 1);
    checkSlot(3, 8'hB0, 1'b1, 0);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b1);

    // Blink: raised just after the start of a frame
    checkSlot(0, 8'hC0, 1'b1, 2);
    checkSlot(1, 8'h92, 1'b1, 0);
    checkSlot(2, 8'hA4, 1'b1, 0);
    checkSlot(3, 8'h99, 1'b1, 0);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b1);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b0);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b0);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b1);
    checkFrame(8'hC0, 8'h92, 8'hA4, 8'h99, 1'b1);
    // Hidden again; drop blink at the start of digit 1's slot
    checkSlot(0, 8'hC0, 1'b0, 0);
    checkSlot(1, 8'h92, 1'b1, 3);
    checkSlot(2, 8'hA4, 1'b1, 0);
    checkSlot(3, 8'h99, 1'b1, 0);

    // Reset during the DRIVE part of digit 2's slot
    checkSlot(0, 8'hC0, 1'b1, 0);
    checkSlot(1, 8'h92, 1'b1, 0);
    tick(); tick(); tick();
    chk("pre_rst_an", 32'(an), 32'h0000000B);
    segIn0 = 8'h88;
    rst = 1'b1;
    tick();
    chk("midrst_an", 32'(an), 32'h0000000F);
    chk("midrst_seg", 32'(seg), 32'h000000FF);
    chk("midrst_ft", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    checkFrame(8'h88, 8'h92, 8'hA4, 8'h99, 1'b1);

    // Default parameters: 1000 blank clocks, then digit 0 driven
    rstDef = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
    end
    chk("def_blank_an", 32'(defAn), 32'h0000000F);
    chk("def_blank_seg", 32'(defSeg), 32'h000000FF);
    tick();
    chk("def_drive_an", 32'(defAn), 32'h0000000E);
    chk("def_drive_seg", 32'(defSeg), 32'h00000088);
    chk("def_ft", 32'(defFt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule

// File: doc/seg_mux_driver.md
SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000: clocks per digit slot (1 kHz slot rate at 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter BLANK_CYCLES, default 1000: anti-ghost blank clocks at the start of each slot; legal range 1..REFRESH_DIV-1.
REQ-003 SHALL have parameter BLINK_FRAMES, default 125: frames per blink half-period; legal range >= 1.
REQ-004 SHALL have port Clk100M, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports segIn0..segIn3, input, 8 bits each: active-low segment patterns for digits 0..3, from the display controller's segOut0..3.
REQ-007 SHALL have port blink, input, 1 bit: 1 enables whole-display blinking.
REQ-008 SHALL have port an, output, 4 bits: active-low digit anodes; an[k] low selects digit k.
REQ-009 SHALL have port seg, output, 8 bits: active-low cathodes {dp,g..a}, driven straight from the snapshot.
REQ-010 SHALL have port frame_tick, output, 1 bit: one-cycle pulse at each frame end.

Function
REQ-011 SHALL hold slot counter cnt (0..REFRESH_DIV-1, width ceil(log2(REFRESH_DIV))) and digit index dig (0..3). cnt increments each clock; at REFRESH_DIV-1 it wraps to 0 and dig increments, 3 wrapping to 0.
REQ-012 SHALL run a two-state FSM per slot: BLANK while cnt < BLANK_CYCLES, DRIVE while cnt >= BLANK_CYCLES. BLANK->DRIVE at cnt==BLANK_CYCLES; DRIVE->BLANK on the cnt wrap.
REQ-013 SHALL load a 4x8 snapshot from segIn0..3 on every edge where cnt==0 and dig==0. This includes the first edge after Reset deasserts.
REQ-014 SHALL keep snapshot contents unchanged between loads. segIn changes mid-frame SHALL NOT appear until the next frame.
REQ-015 SHALL register an and seg. At an edge with state BLANK: an=4'b1111, seg=8'hFF. With state DRIVE and display visible: an = all ones except bit dig low, seg = snapshot[dig].
REQ-016 SHALL assert exactly one an bit low at any time, and only in DRIVE. Anode and segment changes SHALL occur only during BLANK.
REQ-017 SHALL assert frame_tick, registered, for exactly one cycle on the edge where cnt==REFRESH_DIV-1 and dig==3. Period = 4*REFRESH_DIV clocks.
REQ-018 SHALL keep a blink frame counter and a phase bit (visible/hidden). While blink==1, each frame_tick increments the counter. On reaching BLINK_FRAMES the counter clears and the phase toggles.
REQ-019 SHALL force phase=visible and clear the blink counter on any edge with blink==0. While hidden, the DRIVE state outputs an=4'b1111, seg=8'hFF; scanning, snapshot loads and frame_tick continue unchanged.
REQ-020 SHALL start blinking in the visible phase when blink rises. It SHALL return to visible on the edge after blink falls.
REQ-021 SHALL pass segment codes through unmodified; no decoding or width change.

Reset
REQ-022 SHALL, on any edge with Reset==1, set cnt=0, dig=0, state=BLANK, an=4'b1111, seg=8'hFF, snapshot all 8'hFF, frame_tick=0, blink counter=0, phase=visible.
REQ-023 SHALL abort any slot in progress when Reset asserts mid-operation. Reset SHALL take priority over every other update, including snapshot load and frame_tick.
REQ-024 SHALL restart from digit 0, BLANK state, on the first edge after Reset deasserts.

Verification
(Parameters REFRESH_DIV=8, BLANK_CYCLES=2, BLINK_FRAMES=2 unless stated.)
REQ-025 Scan order: segIn0..3 = C0,F9,A4,B0, blink=0, release Reset. Per 8-clock slot: 2 clocks an=1111/seg=FF, then 6 clocks with an=1110/C0, then 1101/F9, 1011/A4, 0111/B0, repeating. frame_tick is high exactly once every 32 clocks.
REQ-026 Tear-free snapshot: change segIn1 from F9 to 92 during digit 2's slot. Digit 1 shows F9 for the rest of that frame and 92 from the next frame on.
REQ-027 Blink: blink=1. The display is visible for 2 frames (64 clocks), then an=1111/seg=FF for 64 clocks, then visible again. Drop blink while hidden: visible from the next DRIVE cycle.
REQ-028 Reset mid-slot: assert Reset for 1 cycle during the DRIVE of digit 2. The next cycle shows an=1111, seg=FF, frame_tick=0. The scan restarts at digit 0, and the snapshot is reloaded with the current segIn.
REQ-029 Defaults and invariants: with defaults, the digit slot is 100000 clocks and the blank time is 1000 clocks. Assert throughout every test that an never has more than one zero bit and that frame_tick is never high for two consecutive cycles.
